// File: rtl/irq_controller_if.sv
// irq_controller_if: CPU-side bus of the interrupt controller.
// Carries the register decode port (select, write strobe, data) and the
// 65C816 interrupt pins. The CPU/register-decode side uses the master modport;
// the controller uses the slave modport.
interface irq_controller_if;
    logic [1:0] reg_sel;
    logic       reg_wr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic       vp;
    logic       irq_n;
    logic       nmi_n;
    logic [3:0] in_service;

    modport master (
        output reg_sel, reg_wr, reg_wdata, vp,
        input  reg_rdata, irq_n, nmi_n, in_service
    );

    modport slave (
        input  reg_sel, reg_wr, reg_wdata, vp,
        output reg_rdata, irq_n, nmi_n, in_service
    );
endinterface

// File: rtl/irq_controller.sv
// irq_controller: eight-source prioritising interrupt controller for the 65C816.
// Sources are synchronised, latched into PENDING (edge or level per source),
// masked, and presented on irq_n. A vector-pull driven FSM latches the index
// of the source being serviced. Bit 0 is the highest priority.
// Optional NMI pulse generator: define IRQ_CTRL_NMI_EN to compile it in;
// without it nmi_src is ignored and nmi_n is held high.
module irq_controller #(
    parameter int NMI_PULSE = 8
) (
    input  logic            clk,
    input  logic            internal_reset,
    input  logic [7:0]      src_req,
    input  logic            nmi_src,
    irq_controller_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND    = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [1:0] SEL_STATUS = 2'd0;
    localparam logic [1:0] SEL_MASK   = 2'd1;
    localparam logic [1:0] SEL_EDGE   = 2'd2;
    localparam logic [1:0] SEL_VECTOR = 2'd3;

    logic [7:0] src_p0, src_p1, src_p2;
    logic [7:0] pending_q, mask_q, edge_q;
    logic [7:0] active, src_rise, pend_set, pend_clr;
    logic [2:0] active_idx;
    state_t     state_q, state_nxt;
    logic       svc_take, svc_done;
    logic       irq_n_q;
    logic [3:0] in_service_q;
    logic       nmi_n_r;
    logic       nmi_ok;

    // Lowest set bit index of a request vector (bit 0 wins).
    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    assign src_rise   = src_p1 & ~src_p2;
    assign pend_set   = (edge_q & src_rise) | (~edge_q & src_p1);
    assign pend_clr   = (bus.reg_wr && bus.reg_sel == SEL_STATUS) ? bus.reg_wdata : 8'h00;
    assign active     = pending_q & mask_q;
    assign active_idx = lowest_idx(active);

    // Request synchroniser (_p0/_p1) and edge-detect history (_p2).
    always_ff @(posedge clk or posedge internal_reset) begin
        if (internal_reset) begin
            src_p0 <= 8'h00;
            src_p1 <= 8'h00;
            src_p2 <= 8'h00;
        end else begin
            src_p0 <= src_req;
            src_p1 <= src_p0;
            src_p2 <= src_p1;
        end
    end

    // PENDING/MASK/EDGE registers; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or posedge internal_reset) begin
        if (internal_reset) begin
            pending_q <= 8'h00;
            mask_q    <= 8'h00;
            edge_q    <= 8'h00;
        end else begin
            pending_q <= (pending_q & ~pend_clr) | pend_set;
            if (bus.reg_wr && bus.reg_sel == SEL_MASK) mask_q <= bus.reg_wdata;
            if (bus.reg_wr && bus.reg_sel == SEL_EDGE) edge_q <= bus.reg_wdata;
        end
    end

    // Combinational register read mux; VECTOR is read-only.
    always_comb begin
        bus.reg_rdata = 8'h00;
        case (bus.reg_sel)
            SEL_STATUS: bus.reg_rdata = pending_q;
            SEL_MASK:   bus.reg_rdata = mask_q;
            SEL_EDGE:   bus.reg_rdata = edge_q;
            SEL_VECTOR: bus.reg_rdata = {|active, 4'b0000, active_idx};
            default:    bus.reg_rdata = 8'h00;
        endcase
    end

`ifdef IRQ_CTRL_NMI_EN
    localparam logic [7:0] NMI_LOAD = 8'(NMI_PULSE);

    logic       nmi_p0, nmi_p1, nmi_p2;
    logic [7:0] nmi_cnt_q;
    logic [2:0] nmi_hold_q;

    // NMI synchroniser, pulse counter and post-pulse holdoff for IRQ service.
    always_ff @(posedge clk or posedge internal_reset) begin
        if (internal_reset) begin
            nmi_p0     <= 1'b0;
            nmi_p1     <= 1'b0;
            nmi_p2     <= 1'b0;
            nmi_cnt_q  <= 8'h00;
            nmi_n_r    <= 1'b1;
            nmi_hold_q <= 3'd0;
        end else begin
            nmi_p0 <= nmi_src;
            nmi_p1 <= nmi_p0;
            nmi_p2 <= nmi_p1;
            // An edge during a running pulse is dropped, not queued.
            if (nmi_cnt_q == 8'h00 && nmi_p1 && !nmi_p2)
                nmi_cnt_q <= NMI_LOAD;
            else if (nmi_cnt_q != 8'h00)
                nmi_cnt_q <= nmi_cnt_q - 8'h01;
            nmi_n_r <= (nmi_cnt_q == 8'h00);
            // Keep IRQ vector pulls blocked for 4 cycles after the pulse ends.
            if (!nmi_n_r)
                nmi_hold_q <= 3'd4;
            else if (nmi_hold_q != 3'd0)
                nmi_hold_q <= nmi_hold_q - 3'd1;
        end
    end

    assign nmi_ok = nmi_n_r && (nmi_hold_q == 3'd0);
`else
    logic unused_nmi;
    assign unused_nmi = nmi_src ^ 1'(NMI_PULSE);
    assign nmi_n_r    = 1'b1;
    assign nmi_ok     = 1'b1;
`endif

    // Service FSM next-state: a vector pull in PEND claims the lowest active source.
    always_comb begin
        state_nxt = state_q;
        svc_take  = 1'b0;
        svc_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|active) state_nxt = PEND;
            end
            PEND: begin
                if (!(|active)) begin
                    state_nxt = IDLE;
                end else if (!bus.vp && nmi_ok) begin
                    state_nxt = SERVICE;
                    svc_take  = 1'b1;
                end
            end
            SERVICE: begin
                if (!active[in_service_q[2:0]]) begin
                    state_nxt = IDLE;
                    svc_done  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state plus registered irq_n and in_service outputs.
    always_ff @(posedge clk or posedge internal_reset) begin
        if (internal_reset) begin
            state_q      <= IDLE;
            irq_n_q      <= 1'b1;
            in_service_q <= 4'h0;
        end else begin
            state_q <= state_nxt;
            irq_n_q <= !((state_nxt != IDLE) && (|active));
            if (svc_take)
                in_service_q <= {1'b1, active_idx};
            else if (svc_done)
                in_service_q <= 4'h0;
        end
    end

    assign bus.irq_n      = irq_n_q;
    assign bus.nmi_n      = nmi_n_r;
    assign bus.in_service = in_service_q;
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: scenario tasks for irq_controller with a queue of
// expected values pushed as stimulus is applied and popped at sample time.
module tb_irq_controller;
    logic       clk;
    logic       internal_reset;
    logic [7:0] src_req;
    logic       nmi_src;

    irq_controller_if bus();

    irq_controller #(.NMI_PULSE(8)) dut (
        .clk            (clk),
        .internal_reset (internal_reset),
        .src_req        (src_req),
        .nmi_src        (nmi_src),
        .bus            (bus)
    );

    typedef struct {
        string      name;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   vectors;
    int   miscompares;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] s);
        bus.reg_sel = s;
        #1;
    endtask

    task automatic wr(input logic [1:0] s, input logic [7:0] d);
        bus.reg_sel   = s;
        bus.reg_wdata = d;
        bus.reg_wr    = 1'b1;
        @(negedge clk);
        bus.reg_wr    = 1'b0;
    endtask

    task automatic test_reset();
        internal_reset = 1'b1;
        src_req = 8'h00; nmi_src = 1'b0;
        bus.vp = 1'b1; bus.reg_wr = 1'b0; bus.reg_sel = 2'd0; bus.reg_wdata = 8'h00;
        sb.push_back('{name:"rst_outputs", val:8'h3});
        sb.push_back('{name:"rst_vector", val:8'h00});
        step(2);
        e = sb.pop_front(); vectors++;
        if ({4'h0, bus.in_service} !== 8'h00 || {6'b0, bus.nmi_n, bus.irq_n} !== e.val) begin
            miscompares++;
            $display("FAIL %s: irq_n=%b nmi_n=%b in_service=%h, expected 1 1 0", e.name, bus.irq_n, bus.nmi_n, bus.in_service);
        end
        rd(2'd3);
        e = sb.pop_front(); vectors++;
        if (bus.reg_rdata !== e.val) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, bus.reg_rdata, e.val); end
        @(negedge clk);
        internal_reset = 1'b0;
        step(1);
    endtask

    task automatic test_level_irq();
        wr(2'd1, 8'hFF);
        wr(2'd2, 8'h00);
        src_req = 8'h04;
        sb.push_back('{name:"irq_n_before_4", val:8'h01});
        sb.push_back('{name:"irq_n_at_4", val:8'h00});
        sb.push_back('{name:"vector_lvl", val:8'h82});
        step(3);
        e = sb.pop_front(); vectors++;
        if ({7'b0, bus.irq_n} !== e.val) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, bus.irq_n, e.val); end
        step(1);
        e = sb.pop_front(); vectors++;
        if ({7'b0, bus.irq_n} !== e.val) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, bus.irq_n, e.val); end
        rd(2'd3);
        e = sb.pop_front(); vectors++;
        if (bus.reg_rdata !== e.val) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, bus.reg_rdata, e.val); end
    endtask

    task automatic test_service();
        bus.vp = 1'b0;
        sb.push_back('{name:"in_service_take", val:8'h0A});
        step(2);
        bus.vp = 1'b1;
        e = sb.pop_front(); vectors++;
        if ({4'h0, bus.in_service} !== e.val) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, bus.in_service, e.val); end
        src_req = 8'h00;
        step(4);
        sb.push_back('{name:"irq_n_clr_1", val:8'h00});
        sb.push_back('{name:"irq_n_clr_2", val:8'h01});
        sb.push_back('{name:"in_service_clr", val:8'h00});
        wr(2'd0, 8'h04);
        e = sb.pop_front(); vectors++;
        if ({7'b0, bus.irq_n} !== e.val) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, bus.irq_n, e.val); end
        step(1);
        e = sb.pop_front(); vectors++;
        if ({7'b0, bus.irq_n} !== e.val) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, bus.irq_n, e.val); end
        e = sb.pop_front(); vectors++;
        if ({4'h0, bus.in_service} !== e.val) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, bus.in_service, e.val); end
    endtask

    task automatic test_edge_mask();
        wr(2'd2, 8'hFF);
        wr(2'd1, 8'h01);
        src_req = 8'h21;
        sb.push_back('{name:"status_edge", val:8'h21});
        sb.push_back('{name:"vector_edge", val:8'h80});
        sb.push_back('{name:"irq_n_edge", val:8'h00});
        sb.push_back('{name:"irq_n_unmasked", val:8'h01});
        step(2);
        src_req = 8'h00;
        step(4);
        rd(2'd0);
        e = sb.pop_front(); vectors++;
        if (bus.reg_rdata !== e.val) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, bus.reg_rdata, e.val); end
        rd(2'd3);
        e = sb.pop_front(); vectors++;
        if (bus.reg_rdata !== e.val) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, bus.reg_rdata, e.val); end
        e = sb.pop_front(); vectors++;
        if ({7'b0, bus.irq_n} !== e.val) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, bus.irq_n, e.val); end
        wr(2'd1, 8'h00);
        step(1);
        e = sb.pop_front(); vectors++;
        if ({7'b0, bus.irq_n} !== e.val) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, bus.irq_n, e.val); end
        wr(2'd0, 8'hFF);
    endtask

    task automatic test_set_clear_race();
        src_req = 8'h08;
        step(2);
        src_req = 8'h00;
        step(5);
        sb.push_back('{name:"status_bit3", val:8'h08});
        sb.push_back('{name:"status_set_wins", val:8'h08});
        sb.push_back('{name:"status_w1c", val:8'h00});
        rd(2'd0);
        e = sb.pop_front(); vectors++;
        if (bus.reg_rdata !== e.val) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, bus.reg_rdata, e.val); end
        src_req = 8'h08;
        step(2);
        wr(2'd0, 8'h08);
        src_req = 8'h00;
        rd(2'd0);
        e = sb.pop_front(); vectors++;
        if (bus.reg_rdata !== e.val) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, bus.reg_rdata, e.val); end
        step(4);
        wr(2'd0, 8'h08);
        rd(2'd0);
        e = sb.pop_front(); vectors++;
        if (bus.reg_rdata !== e.val) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, bus.reg_rdata, e.val); end
    endtask

`ifdef IRQ_CTRL_NMI_EN
    task automatic test_nmi();
        int lows;
        int bad;
        lows = 0; bad = 0;
        wr(2'd2, 8'h00);
        wr(2'd1, 8'hFF);
        src_req = 8'h04;
        step(5);
        nmi_src = 1'b1;
        sb.push_back('{name:"nmi_n_before_4", val:8'h01});
        sb.push_back('{name:"nmi_n_at_4", val:8'h00});
        sb.push_back('{name:"nmi_pulse_width", val:8'h08});
        sb.push_back('{name:"vp_blocked_by_nmi", val:8'h00});
        sb.push_back('{name:"in_service_after_nmi", val:8'h0A});
        step(1);
        nmi_src = 1'b0;
        step(2);
        e = sb.pop_front(); vectors++;
        if ({7'b0, bus.nmi_n} !== e.val) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, bus.nmi_n, e.val); end
        step(1);
        e = sb.pop_front(); vectors++;
        if ({7'b0, bus.nmi_n} !== e.val) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, bus.nmi_n, e.val); end
        bus.vp = 1'b0;
        for (int i = 0; i < 19; i++) begin
            if (bus.nmi_n === 1'b0) lows++;
            if (i <= 11 && bus.in_service !== 4'h0) bad++;
            if (i == 2) nmi_src = 1'b1;
            if (i == 3) nmi_src = 1'b0;
            step(1);
        end
        bus.vp = 1'b1;
        e = sb.pop_front(); vectors++;
        if (lows[7:0] !== e.val) begin miscompares++; $display("FAIL %s: got %0d expected %0d", e.name, lows, e.val); end
        e = sb.pop_front(); vectors++;
        if (bad[7:0] !== e.val) begin miscompares++; $display("FAIL %s: got %0d bad samples expected %0d", e.name, bad, e.val); end
        e = sb.pop_front(); vectors++;
        if ({4'h0, bus.in_service} !== e.val) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, bus.in_service, e.val); end
        src_req = 8'h00;
        step(4);
        wr(2'd0, 8'hFF);
        step(3);
    endtask
`else
    task automatic test_nmi();
        int lows;
        lows = 0;
        wr(2'd2, 8'h00);
        wr(2'd1, 8'hFF);
        src_req = 8'h04;
        step(5);
        nmi_src = 1'b1;
        sb.push_back('{name:"nmi_n_disabled", val:8'h00});
        sb.push_back('{name:"in_service_no_qual", val:8'h0A});
        step(1);
        nmi_src = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.nmi_n !== 1'b1) lows++;
            step(1);
        end
        e = sb.pop_front(); vectors++;
        if (lows[7:0] !== e.val) begin miscompares++; $display("FAIL %s: got %0d low samples expected %0d", e.name, lows, e.val); end
        nmi_src = 1'b1;
        step(3);
        bus.vp = 1'b0;
        step(1);
        bus.vp = 1'b1;
        e = sb.pop_front(); vectors++;
        if ({4'h0, bus.in_service} !== e.val) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, bus.in_service, e.val); end
        nmi_src = 1'b0;
        src_req = 8'h00;
        step(4);
        wr(2'd0, 8'hFF);
        step(3);
    endtask
`endif

    task automatic test_reset_mid();
        int n;
        wr(2'd2, 8'h00);
        wr(2'd1, 8'hFF);
        src_req = 8'h04;
        step(5);
        bus.vp = 1'b0;
        sb.push_back('{name:"pre_reset_service", val:8'h0A});
        step(1);
        bus.vp = 1'b1;
        e = sb.pop_front(); vectors++;
        if ({4'h0, bus.in_service} !== e.val) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, bus.in_service, e.val); end
`ifdef IRQ_CTRL_NMI_EN
        nmi_src = 1'b1;
        sb.push_back('{name:"pre_reset_nmi_low", val:8'h00});
        step(1);
        nmi_src = 1'b0;
        n = 0;
        while (bus.nmi_n !== 1'b0 && n < 10) begin step(1); n++; end
        e = sb.pop_front(); vectors++;
        if ({7'b0, bus.nmi_n} !== e.val) begin miscompares++; $display("FAIL %s: got %h expected %h (timeout)", e.name, bus.nmi_n, e.val); end
`else
        n = 0;
`endif
        sb.push_back('{name:"async_rst_irq_nmi", val:8'h03});
        sb.push_back('{name:"async_rst_in_service", val:8'h00});
        sb.push_back('{name:"async_rst_mask", val:8'h00});
        #2;
        internal_reset = 1'b1;
        #1;
        e = sb.pop_front(); vectors++;
        if ({6'b0, bus.nmi_n, bus.irq_n} !== e.val) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, {bus.nmi_n, bus.irq_n}, e.val); end
        e = sb.pop_front(); vectors++;
        if ({4'h0, bus.in_service} !== e.val) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, bus.in_service, e.val); end
        rd(2'd1);
        e = sb.pop_front(); vectors++;
        if (bus.reg_rdata !== e.val) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, bus.reg_rdata, e.val); end
        @(negedge clk);
        internal_reset = 1'b0;
        sb.push_back('{name:"repend_early", val:8'h00});
        sb.push_back('{name:"repend_level", val:8'h04});
        step(2);
        rd(2'd0);
        e = sb.pop_front(); vectors++;
        if (bus.reg_rdata !== e.val) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, bus.reg_rdata, e.val); end
        step(1);
        rd(2'd0);
        e = sb.pop_front(); vectors++;
        if (bus.reg_rdata !== e.val) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, bus.reg_rdata, e.val); end
        src_req = 8'h00;
        if (n > 100) $display("note: unexpected wait count %0d", n);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_level_irq();
        test_service();
        test_edge_mask();
        test_set_clear_race();
        test_nmi();
        test_reset_mid();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
